// File: rtl/rvv_backend_dispatch_vreg_scoreboard_pkg.sv
// Shared types and constants for the dispatch vector-register scoreboard.
// Optional feature macro used by the top: RVV_SB_WB_BYPASS_EN.
package rvv_backend_dispatch_vreg_scoreboard_pkg;

  localparam int VREG_NUM         = 32;
  localparam int V0_INDEX         = 0;
  localparam int SB_CNT_W_DEFAULT = 3;

  typedef enum logic {
    XRF = 1'b0,
    VRF = 1'b1
  } W_TYPE_t;

  typedef struct packed {
    logic [4:0] vd_index;
    logic       vs3_valid;
    logic [4:0] vs1_index;
    logic       vs1_valid;
    logic [4:0] vs2_index;
    logic       vs2_valid;
    logic       vm;
  } SUC_UOP_RAW_t;

  typedef struct packed {
    logic vd_wait;
    logic vs1_wait;
    logic vs2_wait;
    logic v0_wait;
  } RAW_UOP_UOP_t;

  typedef struct packed {
    logic [4:0] w_index;
    W_TYPE_t    w_type;
  } SB_DISP_t;

  function automatic int cnt_max(input int width);
    return (1 << width) - 1;
  endfunction

endpackage

// File: rtl/rvv_backend_dispatch_vreg_scoreboard_sb_entry.sv
// One pending-write counter: same-cycle inc/dec in signed arithmetic,
// clamped at zero with an underflow pulse; flush empties it.
module rvv_backend_dispatch_sb_entry #(
  parameter int SB_CNT_W = 3,
  parameter int INC_W    = 2,
  parameter int DEC_W    = 3
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                flush,
  input  logic [INC_W-1:0]    inc,
  input  logic [DEC_W-1:0]    dec,
  output logic [SB_CNT_W-1:0] cnt,
  output logic                underflow
);

  localparam int MAX_W = (SB_CNT_W > INC_W) ? ((SB_CNT_W > DEC_W) ? SB_CNT_W : DEC_W)
                                            : ((INC_W > DEC_W) ? INC_W : DEC_W);
  localparam int SUM_W = MAX_W + 2;
  localparam logic signed [SUM_W-1:0] CNT_MAX = SUM_W'((1 << SB_CNT_W) - 1);

  logic signed [SUM_W-1:0] net;
  logic [SB_CNT_W-1:0]     cnt_d, cnt_q;

  function automatic logic [SB_CNT_W-1:0] sat_count(input logic signed [SUM_W-1:0] v);
    if (v < 0) return '0;
    if (v > CNT_MAX) return CNT_MAX[SB_CNT_W-1:0];
    return v[SB_CNT_W-1:0];
  endfunction

  always_comb begin
    net       = $signed(SUM_W'(cnt_q)) + $signed(SUM_W'(inc)) - $signed(SUM_W'(dec));
    underflow = ~flush & (net < 0);
    cnt_d     = flush ? '0 : sat_count(net);
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/rvv_backend_dispatch_vreg_scoreboard.sv
// Per-VRF pending-write scoreboard: source wait flags, in-order dispatch throttle,
// writeback retire. RVV_SB_WB_BYPASS_EN lets same-cycle writebacks clear waits.
module rvv_backend_dispatch_vreg_scoreboard
  import rvv_backend_dispatch_vreg_scoreboard_pkg::*;
#(
  parameter int DISPATCH_NUM = 2,
  parameter int WB_NUM       = 4,
  parameter int SB_CNT_W     = SB_CNT_W_DEFAULT
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  SUC_UOP_RAW_t             query_uop [DISPATCH_NUM],
  output RAW_UOP_UOP_t             query_wait [DISPATCH_NUM],
  input  logic [DISPATCH_NUM-1:0]  disp_valid,
  output logic [DISPATCH_NUM-1:0]  disp_ready,
  input  SB_DISP_t                 disp_w [DISPATCH_NUM],
  input  logic [WB_NUM-1:0]        wb_valid,
  input  logic [WB_NUM-1:0][4:0]   wb_w_index,
  output logic [VREG_NUM-1:0]      busy,
  output logic                     sb_err
);

  localparam int INC_W = $clog2(DISPATCH_NUM + 1);
  localparam int DEC_W = $clog2(WB_NUM + 1);
  localparam int CHK_W = SB_CNT_W + INC_W + 1;
  localparam logic [CHK_W-1:0] CNT_MAX = CHK_W'(cnt_max(SB_CNT_W));

  logic [SB_CNT_W-1:0]     cnt [VREG_NUM];
  logic [INC_W-1:0]        inc [VREG_NUM];
  logic [DEC_W-1:0]        dec [VREG_NUM];
  logic [VREG_NUM-1:0]     underflow;
  logic [DISPATCH_NUM-1:0] fire;
  logic                    sb_err_d, sb_err_q;

  function automatic logic pending(input logic [4:0] idx);
`ifdef RVV_SB_WB_BYPASS_EN
    localparam int CMP_W = (SB_CNT_W > DEC_W) ? SB_CNT_W : DEC_W;
    return CMP_W'(cnt[idx]) > CMP_W'(dec[idx]);
`else
    return cnt[idx] != '0;
`endif
  endfunction

  // Acceptance is checked against counters before this cycle's retires.
  always_comb begin : accept
    logic             chain;
    logic [INC_W-1:0] same;
    logic [CHK_W-1:0] need;
    chain = ~flush;
    same  = '0;
    need  = '0;
    for (int i = 0; i < DISPATCH_NUM; i++) begin
      same = '0;
      for (int k = 0; k < i; k++) begin
        if (disp_w[k].w_type == VRF && disp_w[k].w_index == disp_w[i].w_index)
          same = same + INC_W'(1);
      end
      need          = CHK_W'(cnt[disp_w[i].w_index]) + CHK_W'(same) + CHK_W'(1);
      chain         = chain & ((disp_w[i].w_type != VRF) | (need <= CNT_MAX));
      disp_ready[i] = chain;
    end
  end

  assign fire = disp_valid & disp_ready;

  always_comb begin : inc_dec
    for (int r = 0; r < VREG_NUM; r++) begin
      inc[r] = '0;
      dec[r] = '0;
    end
    for (int i = 0; i < DISPATCH_NUM; i++) begin
      if (fire[i] && disp_w[i].w_type == VRF)
        inc[disp_w[i].w_index] = inc[disp_w[i].w_index] + INC_W'(1);
    end
    for (int j = 0; j < WB_NUM; j++) begin
      if (wb_valid[j])
        dec[wb_w_index[j]] = dec[wb_w_index[j]] + DEC_W'(1);
    end
  end

  always_comb begin : query
    for (int i = 0; i < DISPATCH_NUM; i++) begin
      query_wait[i]          = '0;
      query_wait[i].vs1_wait = query_uop[i].vs1_valid & pending(query_uop[i].vs1_index);
      query_wait[i].vs2_wait = query_uop[i].vs2_valid & pending(query_uop[i].vs2_index);
      query_wait[i].vd_wait  = query_uop[i].vs3_valid & pending(query_uop[i].vd_index);
      query_wait[i].v0_wait  = ~query_uop[i].vm & pending(5'(V0_INDEX));
    end
  end

  for (genvar r = 0; r < VREG_NUM; r++) begin : g_entry
    rvv_backend_dispatch_sb_entry #(
      .SB_CNT_W (SB_CNT_W),
      .INC_W    (INC_W),
      .DEC_W    (DEC_W)
    ) u_entry (
      .clk       (clk),
      .rst       (rst),
      .flush     (flush),
      .inc       (inc[r]),
      .dec       (dec[r]),
      .cnt       (cnt[r]),
      .underflow (underflow[r])
    );
    assign busy[r] = |cnt[r];
  end

  // Sticky: flush leaves it set so stale writebacks stay visible.
  assign sb_err_d = sb_err_q | (|underflow);

  always_ff @(posedge clk) begin
    if (rst) sb_err_q <= 1'b0;
    else     sb_err_q <= sb_err_d;
  end

  assign sb_err = sb_err_q;

endmodule

// File: tb/tb_rvv_backend_dispatch_vreg_scoreboard.sv
// Directed plus randomized bench for the vreg scoreboard against a count-per-register model.
module tb_rvv_backend_dispatch_vreg_scoreboard;
  import rvv_backend_dispatch_vreg_scoreboard_pkg::*;

  localparam int MAXC = 7;
`ifdef RVV_SB_WB_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic               rst, flush;
  SUC_UOP_RAW_t       query_uop [2];
  RAW_UOP_UOP_t       query_wait [2];
  logic [1:0]         disp_valid, disp_ready;
  SB_DISP_t           disp_w [2];
  logic [3:0]         wb_valid;
  logic [3:0][4:0]    wb_w_index;
  logic [31:0]        busy;
  logic               sb_err;

  int checks = 0;
  int failures = 0;
  int m_cnt [32];
  bit m_err;

  logic [1:0]   obs_ready;
  RAW_UOP_UOP_t obs_wait [2];
  logic [31:0]  obs_busy;
  logic         obs_err;

  rvv_backend_dispatch_vreg_scoreboard dut (
    .clk        (clk),
    .rst        (rst),
    .flush      (flush),
    .query_uop  (query_uop),
    .query_wait (query_wait),
    .disp_valid (disp_valid),
    .disp_ready (disp_ready),
    .disp_w     (disp_w),
    .wb_valid   (wb_valid),
    .wb_w_index (wb_w_index),
    .busy       (busy),
    .sb_err     (sb_err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit m_pend(input int idx);
    int eff;
    eff = m_cnt[idx];
    if (BYP) begin
      for (int j = 0; j < 4; j++)
        if (wb_valid[j] && wb_w_index[j] == 5'(idx)) eff--;
    end
    return eff > 0;
  endfunction

  function automatic RAW_UOP_UOP_t m_wait(input SUC_UOP_RAW_t q);
    RAW_UOP_UOP_t e;
    e          = '0;
    e.vs1_wait = q.vs1_valid && m_pend(int'(q.vs1_index));
    e.vs2_wait = q.vs2_valid && m_pend(int'(q.vs2_index));
    e.vd_wait  = q.vs3_valid && m_pend(int'(q.vd_index));
    e.v0_wait  = !q.vm && m_pend(0);
    return e;
  endfunction

  task automatic idle();
    flush      = 1'b0;
    disp_valid = '0;
    wb_valid   = '0;
    wb_w_index = '0;
    for (int i = 0; i < 2; i++) begin
      disp_w[i]       = '{w_index: 5'd0, w_type: XRF};
      query_uop[i]    = '0;
      query_uop[i].vm = 1'b1;
    end
  endtask

  // Check outputs mid-cycle, then advance the model across the next rising edge.
  task automatic cycle();
    int         tmp [32];
    int         nxt [32];
    bit         stop, nerr;
    logic [1:0] er;
    logic [31:0] eb;
    @(negedge clk);
    tmp  = m_cnt;
    stop = 0;
    er   = '0;
    for (int i = 0; i < 2; i++) begin
      if (flush || stop) er[i] = 1'b0;
      else if (disp_w[i].w_type == VRF) begin
        if (tmp[disp_w[i].w_index] + 1 > MAXC) stop = 1;
        else begin
          tmp[disp_w[i].w_index]++;
          er[i] = 1'b1;
        end
      end else er[i] = 1'b1;
    end
    eb = '0;
    for (int r = 0; r < 32; r++) eb[r] = (m_cnt[r] != 0);
    obs_ready   = disp_ready;
    obs_wait[0] = query_wait[0];
    obs_wait[1] = query_wait[1];
    obs_busy    = busy;
    obs_err     = sb_err;
    chk("disp_ready", 32'(obs_ready), 32'(er));
    chk("query_wait0", 32'(obs_wait[0]), 32'(m_wait(query_uop[0])));
    chk("query_wait1", 32'(obs_wait[1]), 32'(m_wait(query_uop[1])));
    chk("busy", obs_busy, eb);
    chk("sb_err", 32'(obs_err), 32'(m_err));
    nerr = m_err;
    nxt  = m_cnt;
    if (rst) begin
      for (int r = 0; r < 32; r++) nxt[r] = 0;
      nerr = 0;
    end else if (flush) begin
      for (int r = 0; r < 32; r++) nxt[r] = 0;
    end else begin
      for (int i = 0; i < 2; i++)
        if (er[i] && disp_valid[i] && disp_w[i].w_type == VRF) nxt[disp_w[i].w_index]++;
      for (int j = 0; j < 4; j++)
        if (wb_valid[j]) nxt[wb_w_index[j]]--;
      for (int r = 0; r < 32; r++)
        if (nxt[r] < 0) begin
          nxt[r] = 0;
          nerr   = 1;
        end
    end
    @(posedge clk);
    #1;
    m_cnt = nxt;
    m_err = nerr;
  endtask

  initial begin
    int tmp [32];
    int st, pick;
    idle();
    rst = 1'b1;
    for (int r = 0; r < 32; r++) m_cnt[r] = 0;
    m_err = 0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    // Reset state with a valid vs1 query on v3
    query_uop[0].vs1_index = 5'd3;
    query_uop[0].vs1_valid = 1'b1;
    cycle();
    chk("rst_wait0", 32'(obs_wait[0]), 32'h0);
    chk("rst_busy", obs_busy, 32'h0);
    chk("rst_ready", 32'(obs_ready), 32'h3);
    chk("rst_err", 32'(obs_err), 32'h0);

    // Fire on v3, then wait on vs2=v3 until writeback
    idle();
    disp_valid = 2'b01;
    disp_w[0]  = '{w_index: 5'd3, w_type: VRF};
    cycle();
    idle();
    query_uop[0].vs2_index = 5'd3;
    query_uop[0].vs2_valid = 1'b1;
    cycle();
    chk("raw_vs2_wait", 32'(obs_wait[0].vs2_wait), 32'h1);
    chk("raw_busy3", 32'(obs_busy[3]), 32'h1);
    wb_valid[0]   = 1'b1;
    wb_w_index[0] = 5'd3;
    cycle();
    chk("wb_same_cycle_wait", 32'(obs_wait[0].vs2_wait), BYP ? 32'h0 : 32'h1);
    wb_valid = '0;
    cycle();
    chk("wb_next_cycle_wait", 32'(obs_wait[0].vs2_wait), 32'h0);
    chk("wb_busy3", 32'(obs_busy[3]), 32'h0);

    // Fill v5 to the limit, check throttling
    idle();
    disp_w[0]  = '{w_index: 5'd5, w_type: VRF};
    disp_w[1]  = '{w_index: 5'd5, w_type: VRF};
    disp_valid = 2'b11;
    repeat (3) cycle();
    disp_valid = 2'b01;
    cycle();
    disp_valid = 2'b00;
    cycle();
    chk("ovf_full_ready", 32'(obs_ready), 32'h0);
    wb_valid[0]   = 1'b1;
    wb_w_index[0] = 5'd5;
    cycle();
    wb_valid = '0;
    cycle();
    chk("ovf_one_left_ready", 32'(obs_ready), 32'h1);
    chk("ovf_busy5", 32'(obs_busy[5]), 32'h1);
    wb_valid   = 4'b1111;
    wb_w_index = {5'd5, 5'd5, 5'd5, 5'd5};
    cycle();
    wb_valid = 4'b0011;
    cycle();

    // Fire and writeback on v2 in the same cycle
    idle();
    disp_valid = 2'b01;
    disp_w[0]  = '{w_index: 5'd2, w_type: VRF};
    cycle();
    wb_valid[0]   = 1'b1;
    wb_w_index[0] = 5'd2;
    cycle();
    idle();
    cycle();
    chk("fire_wb_busy2", 32'(obs_busy[2]), 32'h1);
    chk("fire_wb_err", 32'(obs_err), 32'h0);
    wb_valid[0]   = 1'b1;
    wb_w_index[0] = 5'd2;
    cycle();

    // v0 mask dependency
    idle();
    disp_valid = 2'b01;
    disp_w[0]  = '{w_index: 5'd0, w_type: VRF};
    cycle();
    idle();
    query_uop[0].vm = 1'b0;
    cycle();
    chk("v0_wait_vm0", 32'(obs_wait[0].v0_wait), 32'h1);
    query_uop[0].vm = 1'b1;
    cycle();
    chk("v0_wait_vm1", 32'(obs_wait[0].v0_wait), 32'h0);
    wb_valid[0]   = 1'b1;
    wb_w_index[0] = 5'd0;
    cycle();

    // Flush then stale writeback underflows; sticky until rst
    idle();
    disp_valid = 2'b11;
    disp_w[0]  = '{w_index: 5'd7, w_type: VRF};
    disp_w[1]  = '{w_index: 5'd7, w_type: VRF};
    cycle();
    idle();
    flush = 1'b1;
    cycle();
    chk("flush_ready", 32'(obs_ready), 32'h0);
    flush = 1'b0;
    cycle();
    chk("flush_busy", obs_busy, 32'h0);
    wb_valid[0]   = 1'b1;
    wb_w_index[0] = 5'd7;
    cycle();
    idle();
    cycle();
    chk("underflow_err", 32'(obs_err), 32'h1);
    cycle();
    chk("underflow_err_sticky", 32'(obs_err), 32'h1);
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    cycle();
    chk("err_cleared_by_rst", 32'(obs_err), 32'h0);

    // Randomized traffic concentrated on a few registers
    for (int n = 0; n < 400; n++) begin
      idle();
      rst   = ($urandom % 100) == 0;
      flush = ($urandom % 50) == 0;
      for (int i = 0; i < 2; i++) begin
        disp_valid[i]          = ($urandom % 4) != 0;
        disp_w[i].w_index      = (($urandom % 4) == 0) ? 5'($urandom % 32) : 5'($urandom % 4);
        disp_w[i].w_type       = (($urandom % 5) == 0) ? XRF : VRF;
        query_uop[i].vs1_index = 5'($urandom_range(0, 7));
        query_uop[i].vs2_index = 5'($urandom_range(0, 7));
        query_uop[i].vd_index  = 5'($urandom_range(0, 7));
        query_uop[i].vs1_valid = 1'($urandom);
        query_uop[i].vs2_valid = 1'($urandom);
        query_uop[i].vs3_valid = 1'($urandom);
        query_uop[i].vm        = 1'($urandom);
      end
      tmp = m_cnt;
      for (int j = 0; j < 4; j++) begin
        if (($urandom % 100) < 3) begin
          wb_valid[j]   = 1'b1;
          wb_w_index[j] = 5'($urandom % 32);
        end else if ($urandom % 2 == 1) begin
          st   = int'($urandom % 32);
          pick = -1;
          for (int k = 0; k < 32; k++)
            if (pick < 0 && tmp[(st + k) % 32] > 0) pick = (st + k) % 32;
          if (pick >= 0) begin
            wb_valid[j]   = 1'b1;
            wb_w_index[j] = 5'(pick);
            tmp[pick]--;
          end
        end
      end
      cycle();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
